// File: rtl/conv_ctrl.sv
// Control FSM for a single-lane 1-D convolution: load, compute, output.
// Drives x RAM / filter ROM addresses and accumulator enables; carries no data.
module conv_ctrl #(
    parameter int N    = 96,
    parameter int M    = 65,
    parameter int AW_X = $clog2(N),
    parameter int AW_F = $clog2(M)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            x_valid,
    output logic            x_ready,
    output logic            wr_en_x,
    output logic [AW_X-1:0] addr_x,
    output logic [AW_F-1:0] addr_f,
    output logic            clr_acc,
    output logic            en_acc,
    output logic            y_valid,
    input  logic            y_ready,
    output logic            vec_done
);

    localparam int NUM_OUT = N - M + 1;

    localparam logic [AW_X-1:0] LD_LAST  = AW_X'(N - 1);
    localparam logic [AW_X-1:0] O_LAST   = AW_X'(NUM_OUT - 1);
    localparam logic [AW_F-1:0] K_LAST   = AW_F'(M - 1);
    localparam logic [AW_X-1:0] K_LAST_X = AW_X'(M - 1);

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        WAIT,
        OUTPUT
    } state_t;

    state_t          state, state_n;
    logic [AW_X-1:0] ld, ld_n;
    logic [AW_X-1:0] o, o_n;
    logic [AW_F-1:0] k, k_n;
    logic            issue_d, clr_d;
    logic            accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= LOAD;
            ld      <= '0;
            o       <= '0;
            k       <= '0;
            issue_d <= 1'b0;
            clr_d   <= 1'b0;
        end else begin
            state   <= state_n;
            ld      <= ld_n;
            o       <= o_n;
            k       <= k_n;
            // RAM/ROM reads take one cycle, so enables trail the address
            issue_d <= (state == COMPUTE);
            clr_d   <= (state == COMPUTE) && (k == '0);
        end
    end

    assign en_acc  = issue_d;
    assign clr_acc = clr_d;

    always_comb begin
        state_n  = state;
        ld_n     = ld;
        o_n      = o;
        k_n      = k;
        x_ready  = 1'b0;
        wr_en_x  = 1'b0;
        addr_x   = '0;
        addr_f   = '0;
        y_valid  = 1'b0;
        vec_done = 1'b0;
        accept   = 1'b0;
        unique case (state)
            LOAD: begin
                x_ready = ~reset;
                accept  = x_valid & ~reset;
                wr_en_x = accept;
                addr_x  = ld;
                if (accept) begin
                    if (ld == LD_LAST) begin
                        state_n = COMPUTE;
                        ld_n    = '0;
                        o_n     = '0;
                        k_n     = '0;
                    end else begin
                        ld_n = ld + AW_X'(1);
                    end
                end
            end
            COMPUTE: begin
                addr_x = o + AW_X'(k);
                addr_f = k;
                if (k == K_LAST) begin
                    state_n = WAIT;
                    k_n     = '0;
                end else begin
                    k_n = k + AW_F'(1);
                end
            end
            WAIT: begin
                addr_x  = o + K_LAST_X;
                addr_f  = K_LAST;
                state_n = OUTPUT;
            end
            OUTPUT: begin
                addr_x  = o + K_LAST_X;
                addr_f  = K_LAST;
                y_valid = 1'b1;
                if (y_ready) begin
                    if (o == O_LAST) begin
                        vec_done = 1'b1;
                        o_n      = '0;
                        state_n  = LOAD;
                    end else begin
                        o_n     = o + AW_X'(1);
                        state_n = COMPUTE;
                    end
                end
            end
            default: state_n = LOAD;
        endcase
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl: timeline model of the control outputs plus a
// datapath model whose accumulator is checked against a direct convolution.
module tb_conv_ctrl;

    localparam int N  = 96;
    localparam int M  = 65;
    localparam int NO = N - M + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       x_valid = 1'b0;
    logic       y_ready = 1'b0;
    logic [7:0] x_data = 8'd0;
    logic       x_ready, wr_en_x, clr_acc, en_acc, y_valid, vec_done;
    logic [6:0] addr_x, addr_f;

    always #5 clk = ~clk;

    conv_ctrl #(.N(N), .M(M)) dut (
        .clk(clk), .reset(reset),
        .x_valid(x_valid), .x_ready(x_ready), .wr_en_x(wr_en_x),
        .addr_x(addr_x), .addr_f(addr_f),
        .clr_acc(clr_acc), .en_acc(en_acc),
        .y_valid(y_valid), .y_ready(y_ready), .vec_done(vec_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // 0 = low, 1 = high, 2 = random 50%
    int xv_mode = 0;
    int yr_mode = 0;

    function automatic logic pick(input int m);
        if (m == 2) return logic'($urandom_range(0, 1));
        return logic'(m == 1);
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        x_valid = pick(xv_mode);
        y_ready = pick(yr_mode);
        x_data  = 8'($urandom);
    end

    // model state: ph 0 = loading, 1 = producing output m_o, m_t cycles in
    int     rom[M];
    int     xmem[N];
    int     xr, fr;
    longint acc;
    int     ph, m_ld, m_o, m_t;
    int     vec[$];
    int     n_wr, out_cnt, vec_cnt, cyc, first_acc;

    initial begin
        for (int j = 0; j < M; j++) rom[j] = int'($urandom_range(0, 255));
        for (int j = 0; j < N; j++) xmem[j] = 0;
        xr = 0; fr = 0; acc = 0;
        vec_cnt = 0; out_cnt = 0; n_wr = 0; cyc = 0; first_acc = 0;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ph = 0; m_ld = 0; m_o = 0; m_t = 0;
            vec.delete();
        end else begin
            if (en_acc)
                acc = clr_acc ? longint'(xr * fr) : acc + longint'(xr * fr);
            xr = xmem[addr_x % N];
            fr = rom[addr_f % M];
            if (wr_en_x) xmem[addr_x % N] = int'(x_data);
            if (ph == 0) begin
                if (x_valid) begin
                    if (m_ld == 0) begin
                        vec.delete();
                        first_acc = cyc;
                    end
                    vec.push_back(int'(x_data));
                    n_wr++;
                    if (m_ld == N - 1) begin
                        ph = 1; m_o = 0; m_t = 0; m_ld = 0;
                    end else m_ld++;
                end
            end else if (m_t <= M) begin
                m_t++;
            end else if (y_ready) begin
                out_cnt++;
                if (m_o == NO - 1) begin
                    ph = 0; m_o = 0; vec_cnt++;
                end else begin
                    m_o++; m_t = 0;
                end
            end
            cyc++;
        end
    end

    int en_seen = 0, clr_seen = 0, vd_seen = 0, last_vd = 0;

    always @(negedge clk) begin
        if (!reset) begin
            automatic int e_ax = 0, e_af = 0;
            automatic logic e_xr, e_wr, e_en, e_clr, e_yv, e_vd;
            automatic longint gold = 0;
            e_xr = (ph == 0);
            e_wr = (ph == 0) && x_valid;
            if (ph == 0) e_ax = m_ld;
            else if (m_t < M) begin e_ax = m_o + m_t; e_af = m_t; end
            else begin e_ax = m_o + M - 1; e_af = M - 1; end
            e_en  = (ph == 1) && m_t >= 1 && m_t <= M;
            e_clr = (ph == 1) && m_t == 1;
            e_yv  = (ph == 1) && m_t > M;
            e_vd  = e_yv && y_ready && m_o == NO - 1;
            chk("x_ready", x_ready, e_xr);
            chk("wr_en_x", wr_en_x, e_wr);
            chk("addr_x", addr_x, e_ax);
            chk("addr_f", addr_f, e_af);
            chk("en_acc", en_acc, e_en);
            chk("clr_acc", clr_acc, e_clr);
            chk("y_valid", y_valid, e_yv);
            chk("vec_done", vec_done, e_vd);
            if (e_yv && y_ready) begin
                if (vec.size() == N)
                    for (int j = 0; j < M; j++)
                        gold += longint'(vec[m_o + j] * rom[j]);
                else gold = -1;
                chk("y_data", acc, gold);
            end
            if (en_acc) en_seen++;
            if (clr_acc) clr_seen++;
            if (vec_done) begin vd_seen++; last_vd = cyc; end
        end
    end

    task automatic wait_vecs(input int target, input int budget, input string nm);
        int n;
        n = 0;
        while (vec_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, vec_cnt, target);
    endtask

    initial begin
        int n;
        xv_mode = 1;
        yr_mode = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_x_ready", x_ready, 0);
        chk("rst_wr_en_x", wr_en_x, 0);
        chk("rst_en_acc", en_acc, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_addr_x", addr_x, 0);
        reset = 1'b0;

        // first vector: full-rate load, then a 10-cycle output stall
        n = 0;
        while (ph != 1 && n < 300) begin @(negedge clk); n++; end
        chk("load_writes", n_wr, 96);
        xv_mode = 0;
        n = 0;
        while (!y_valid && n < 300) begin @(negedge clk); n++; end
        chk("first_yv_latency", cyc - first_acc, 162);
        chk("first_en_count", en_seen, 65);
        chk("first_clr_count", clr_seen, 1);
        repeat (10) @(negedge clk);
        chk("stall_y_valid", y_valid, 1);
        yr_mode = 1;
        wait_vecs(1, 5000, "vec1_done");
        chk("vec1_outputs", out_cnt, 32);
        chk("vec1_vd_pulses", vd_seen, 1);

        // second vector at full rate: 2240 cycles end to end
        xv_mode = 1;
        wait_vecs(2, 5000, "vec2_done");
        chk("vec2_cycles", last_vd - first_acc, 2239);
        chk("vec2_x_ready_after", x_ready, 1);
        chk("vec2_vd_pulses", vd_seen, 2);

        // reset between edges in the middle of output 5, tap 30
        xv_mode = 2;
        yr_mode = 2;
        n = 0;
        while (!(ph == 1 && m_o == 5 && m_t == 30) && n < 8000) begin
            @(negedge clk); n++;
        end
        chk("reached_k30_o5", n < 8000, 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_x_ready", x_ready, 0);
        chk("mid_rst_wr_en_x", wr_en_x, 0);
        chk("mid_rst_en_acc", en_acc, 0);
        chk("mid_rst_clr_acc", clr_acc, 0);
        chk("mid_rst_y_valid", y_valid, 0);
        chk("mid_rst_vec_done", vec_done, 0);
        chk("mid_rst_addr_x", addr_x, 0);
        chk("mid_rst_addr_f", addr_f, 0);
        #1 reset = 1'b0;
        wait_vecs(3, 8000, "post_rst_vec");

        // randomized handshakes on both sides
        wait_vecs(17, 14 * 4000, "random_vecs");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
